// File: rtl/n64_vi_stream_gen_pkg.sv
// n64_vi_stream_gen_pkg: shared N64 VI stream constants (timing defaults, sync bit indices, phase encoding).
package n64_vi_stream_gen_pkg;
    localparam int H_W = 11;
    localparam int V_W = 10;
    localparam int DEF_H_TOTAL = 773;
    localparam int DEF_HS_LEN = 57;
    localparam int DEF_CLAMP_START = 64;
    localparam int DEF_CLAMP_LEN = 32;
    localparam int DEF_H_ACT_START = 128;
    localparam int DEF_H_ACT_LEN = 640;
    localparam int DEF_V_TOT_NTSC = 263;
    localparam int DEF_V_TOT_PAL = 313;
    localparam int DEF_VS_LEN = 3;
    localparam int DEF_V_ACT_START = 20;
    localparam int DEF_V_ACT_LEN = 240;
    localparam logic [1:0] PH_SYNC = 2'd0;
    localparam logic [1:0] PH_R = 2'd1;
    localparam logic [1:0] PH_G = 2'd2;
    localparam logic [1:0] PH_B = 2'd3;
    localparam int BIT_NCSYNC = 0;
    localparam int BIT_NHSYNC = 1;
    localparam int BIT_NCLAMP = 2;
    localparam int BIT_NVSYNC = 3;
    localparam logic [6:0] VD_IDLE = 7'h0F;
    // {R,G,B} on/off per bar, index 0 = leftmost (white)
    localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};
    typedef enum logic [1:0] {PAT_BARS, PAT_GRID, PAT_SOLID, PAT_RAMP} pattern_t;
    typedef struct packed {
        logic pal;
        logic interlaced;
        pattern_t pattern;
        logic [20:0] solid;
    } mode_t;
    function automatic logic [6:0] sync_word(input logic nv, input logic nc, input logic nh);
        logic [6:0] w;
        w = '0;
        w[BIT_NVSYNC] = nv;
        w[BIT_NCLAMP] = nc;
        w[BIT_NHSYNC] = nh;
        w[BIT_NCSYNC] = nh & nv;
        return w;
    endfunction
endpackage

// File: rtl/n64_vi_timing_cnt.sv
// n64_vi_timing_cnt: phase/slot/line/field counters with mode sampled at field boundaries.
module n64_vi_timing_cnt
    import n64_vi_stream_gen_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int HS_LEN = DEF_HS_LEN,
    parameter int CLAMP_START = DEF_CLAMP_START,
    parameter int CLAMP_LEN = DEF_CLAMP_LEN,
    parameter int V_TOT_NTSC = DEF_V_TOT_NTSC,
    parameter int V_TOT_PAL = DEF_V_TOT_PAL,
    parameter int VS_LEN = DEF_VS_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           palmode,
    input  logic           interlaced,
    input  logic [1:0]     pattern,
    input  logic [20:0]    solid_rgb,
    output logic [1:0]     phase,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           field,
    output logic           nhsync,
    output logic           nvsync,
    output logic           nclamp,
    output logic           ilace,
    output pattern_t       pat,
    output logic [20:0]    solid
);
    mode_t mode, mode_in;
    logic [V_W-1:0] v_last;
    logic line_end, field_end;

    assign mode_in = '{pal: palmode, interlaced: interlaced, pattern: pattern_t'(pattern), solid: solid_rgb};
    // odd interlaced field is one line shorter
    assign v_last = (mode.pal ? V_W'(V_TOT_PAL - 1) : V_W'(V_TOT_NTSC - 1)) - V_W'(mode.interlaced & field);
    assign line_end = phase == PH_B && h == H_W'(H_TOTAL - 1);
    assign field_end = line_end && v == v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            h <= '0;
            v <= '0;
            field <= 1'b0;
            mode <= '0;
        end else if (!enable) begin
            phase <= '0;
            h <= '0;
            v <= '0;
            field <= 1'b0;
            mode <= mode_in;
        end else begin
            phase <= phase + 2'd1;
            if (phase == PH_B) h <= line_end ? '0 : h + H_W'(1);
            if (line_end) v <= field_end ? '0 : v + V_W'(1);
            if (field_end) begin
                mode <= mode_in;
                field <= mode_in.interlaced & ~field;
            end
        end
    end

    assign nhsync = h >= H_W'(HS_LEN);
    assign nvsync = v >= V_W'(VS_LEN);
    assign nclamp = !(h >= H_W'(CLAMP_START) && h < H_W'(CLAMP_START + CLAMP_LEN));
    assign ilace = mode.interlaced;
    assign pat = mode.pattern;
    assign solid = mode.solid;
endmodule

// File: rtl/n64_vi_stream_gen.sv
// n64_vi_stream_gen: N64 VI-compatible nVDSYNC/VD stream generator with test patterns.
module n64_vi_stream_gen
    import n64_vi_stream_gen_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int HS_LEN = DEF_HS_LEN,
    parameter int CLAMP_START = DEF_CLAMP_START,
    parameter int CLAMP_LEN = DEF_CLAMP_LEN,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_LEN = DEF_H_ACT_LEN,
    parameter int V_TOT_NTSC = DEF_V_TOT_NTSC,
    parameter int V_TOT_PAL = DEF_V_TOT_PAL,
    parameter int VS_LEN = DEF_VS_LEN,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_LEN = DEF_V_ACT_LEN
) (
    input  logic        N64_CLK_i,
    input  logic        RST_i,
    input  logic        enable_i,
    input  logic        palmode_i,
    input  logic        interlaced_i,
    input  logic [1:0]  pattern_i,
    input  logic [20:0] solid_rgb_i,
    output logic        nVDSYNC_o,
    output logic [6:0]  VD_o,
    output logic        field_o,
    output logic        frame_start_o
);
    logic [1:0] phase;
    logic [H_W-1:0] h, x;
    logic [V_W-1:0] v;
    logic field, nhsync, nvsync, nclamp, ilace, h_act, v_act, grid_on;
    pattern_t pat;
    logic [20:0] solid, rgb;
    logic [2:0] bar, bar_c;
    logic [3:0] y_lo;
    logic [6:0] comp, word;

    n64_vi_timing_cnt #(
        .H_TOTAL(H_TOTAL), .HS_LEN(HS_LEN), .CLAMP_START(CLAMP_START), .CLAMP_LEN(CLAMP_LEN),
        .V_TOT_NTSC(V_TOT_NTSC), .V_TOT_PAL(V_TOT_PAL), .VS_LEN(VS_LEN)
    ) u_cnt (
        .clk(N64_CLK_i), .rst(RST_i), .enable(enable_i), .palmode(palmode_i),
        .interlaced(interlaced_i), .pattern(pattern_i), .solid_rgb(solid_rgb_i),
        .phase(phase), .h(h), .v(v), .field(field), .nhsync(nhsync), .nvsync(nvsync),
        .nclamp(nclamp), .ilace(ilace), .pat(pat), .solid(solid)
    );

    assign x = h - H_W'(H_ACT_START);
    assign y_lo = v[3:0] - 4'(V_ACT_START);
    assign h_act = h >= H_W'(H_ACT_START) && h < H_W'(H_ACT_START + H_ACT_LEN);
    assign v_act = v >= V_W'(V_ACT_START) && v < V_W'(V_ACT_START + V_ACT_LEN);
    assign bar = 3'(x / H_W'(H_ACT_LEN / 8));
    assign bar_c = BAR_RGB[bar];
    assign grid_on = x[3:0] == 4'd0 || y_lo == 4'd0;

    always_comb begin
        rgb = !(h_act && v_act) ? '0 :
              pat == PAT_BARS  ? {{7{bar_c[2]}}, {7{bar_c[1]}}, {7{bar_c[0]}}} :
              pat == PAT_GRID  ? {21{grid_on}} :
              pat == PAT_SOLID ? solid : {3{x[6:0]}};
        comp = phase == PH_R ? rgb[20:14] : phase == PH_G ? rgb[13:7] : rgb[6:0];
        word = phase == PH_SYNC ? sync_word(nvsync, nclamp, nhsync) : comp;
    end

    always_ff @(posedge N64_CLK_i or posedge RST_i) begin
        if (RST_i || !enable_i) begin
            nVDSYNC_o <= 1'b1;
            VD_o <= VD_IDLE;
            field_o <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            nVDSYNC_o <= phase != PH_SYNC;
            VD_o <= word;
            field_o <= field;
            frame_start_o <= phase == PH_SYNC && h == '0 && v == '0 && (!ilace || !field);
        end
    end
endmodule
